// File: rtl/udp_tx_pkg.sv
// Shared UDP TX types (NoC header, metadata, UDP header, tracker stats) and
// the payload length helpers used by the NoC-to-stream front end.
package udp_tx_pkg;

  localparam int UDP_HDR_BYTES = 8;
  localparam int MSG_LEN_W     = 8;

  typedef struct packed {
    logic [15:0] packet_id;
    logic [63:0] timestamp;
  } tracker_stats_struct;

  // Occupies the low bits of the NoC header flit
  typedef struct packed {
    logic [15:0]          dst_id;
    logic [15:0]          src_id;
    logic [7:0]           msg_type;
    logic [MSG_LEN_W-1:0] msg_len;
    tracker_stats_struct  stats;
  } beehive_noc_hdr_flit;

  // Occupies the low bits of the metadata flit
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_tx_metadata_flit;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] chksum;
  } udp_pkt_hdr;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_META,
    ST_HDR_OUT,
    ST_DATA,
    ST_DRAIN
  } tx_state_e;

  // Number of payload flits needed to carry len bytes, 2**bytes_w bytes per flit
  function automatic logic [15:0] exp_flits(input logic [15:0] len, input int bytes_w);
    logic [16:0] sum;
    sum = {1'b0, len} + 17'((1 << bytes_w) - 1);
    return 16'(sum >> bytes_w);
  endfunction

endpackage

// File: rtl/udp_tx_noc_in_param_ctrl.sv
// Packet sequencing FSM for the NoC-to-UDP-stream front end; datapath
// registers and length arithmetic live in the parent.
//
// state    | meaning
// HDR      | waiting for the NoC header flit
// META     | waiting for the UDP metadata flit, length check on accept
// HDR_OUT  | presenting the UDP header until accepted
// DATA     | payload flits pass straight through to the stream
// DRAIN    | length mismatch: discard the rest of the message
module udp_tx_noc_in_param_ctrl
  import udp_tx_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      noc_in_val,
  input  logic      hdr_out_rdy,
  input  logic      data_out_rdy,
  input  logic      rem_zero,
  input  logic      rem_one,
  input  logic      len_ok,
  input  logic      dec_zero,
  output tx_state_e state,
  output logic      noc_in_rdy,
  output logic      hdr_out_val,
  output logic      data_out_val,
  output logic      ld_hdr,
  output logic      ld_meta,
  output logic      dec_rem
);

  tx_state_e nxt;
  logic      rst_done;

  // Keeps noc_in_rdy low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HDR;
    else        state <= nxt;
  end

  always_comb begin
    nxt          = state;
    noc_in_rdy   = 1'b0;
    hdr_out_val  = 1'b0;
    data_out_val = 1'b0;
    ld_hdr       = 1'b0;
    ld_meta      = 1'b0;
    dec_rem      = 1'b0;
    case (state)
      ST_HDR: begin
        noc_in_rdy = rst_done;
        if (noc_in_val && rst_done) begin
          ld_hdr = 1'b1;
          nxt    = ST_META;
        end
      end
      ST_META: begin
        noc_in_rdy = 1'b1;
        if (noc_in_val) begin
          ld_meta = 1'b1;
          dec_rem = 1'b1;
          if (!len_ok) nxt = dec_zero ? ST_HDR : ST_DRAIN;
          else         nxt = ST_HDR_OUT;
        end
      end
      ST_HDR_OUT: begin
        hdr_out_val = 1'b1;
        if (hdr_out_rdy) nxt = rem_zero ? ST_HDR : ST_DATA;
      end
      ST_DATA: begin
        data_out_val = noc_in_val;
        noc_in_rdy   = data_out_rdy;
        if (noc_in_val && data_out_rdy) begin
          dec_rem = 1'b1;
          if (rem_one) nxt = ST_HDR;
        end
      end
      ST_DRAIN: begin
        noc_in_rdy = 1'b1;
        if (noc_in_val) begin
          dec_rem = 1'b1;
          if (rem_one) nxt = ST_HDR;
        end
      end
      default: nxt = ST_HDR;
    endcase
  end

endmodule

// File: rtl/udp_tx_noc_in_param.sv
// NoC flits (header, metadata, payload) to UDP header + payload stream.
// Optional UDP_TX_NOC_IN_TIMESTAMP_EN forwards the header flit tracker stats.
module udp_tx_noc_in_param
  import udp_tx_pkg::*;
#(
  parameter int DATA_W = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                noc_in_val,
  input  logic [DATA_W-1:0]   noc_in_data,
  output logic                noc_in_rdy,
  output logic                hdr_out_val,
  input  logic                hdr_out_rdy,
  output logic [31:0]         hdr_out_src_ip,
  output logic [31:0]         hdr_out_dst_ip,
  output udp_pkt_hdr          hdr_out_udp_hdr,
  output tracker_stats_struct hdr_out_timestamp,
  output logic                data_out_val,
  input  logic                data_out_rdy,
  output logic [DATA_W-1:0]   data_out_data,
  output logic                data_out_last,
  output logic [$clog2(DATA_W/8):0] data_out_padbytes,
  output logic                len_err
);

  localparam int DATA_BYTES = DATA_W / 8;
  localparam int BYTES_W    = $clog2(DATA_BYTES);
  localparam int PAD_W      = BYTES_W + 1;
  localparam int HDR_FLIT_W = $bits(beehive_noc_hdr_flit);
  localparam int META_W     = $bits(udp_tx_metadata_flit);

  tx_state_e            state;
  beehive_noc_hdr_flit  hdr_in;
  udp_tx_metadata_flit  meta_in;
  logic [MSG_LEN_W-1:0] remaining, rem_dec;
  logic [15:0]          exp_len;
  logic                 len_ok, ld_hdr, ld_meta, dec_rem, rem_one;
  logic [BYTES_W-1:0]   pad_lsb_r;
  logic                 len_err_r;
  logic [31:0]          src_ip_r, dst_ip_r;
  udp_pkt_hdr           udp_hdr_r;
  logic                 unused_hdr_bits;

  assign hdr_in  = noc_in_data[HDR_FLIT_W-1:0];
  assign meta_in = noc_in_data[META_W-1:0];

  assign rem_dec = (remaining == '0) ? '0 : remaining - MSG_LEN_W'(1);
  assign rem_one = (remaining == MSG_LEN_W'(1));
  assign exp_len = exp_flits(meta_in.data_length, BYTES_W);
  assign len_ok  = (exp_len == 16'(rem_dec));

  udp_tx_noc_in_param_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .noc_in_val   (noc_in_val),
    .hdr_out_rdy  (hdr_out_rdy),
    .data_out_rdy (data_out_rdy),
    .rem_zero     (remaining == '0),
    .rem_one      (rem_one),
    .len_ok       (len_ok),
    .dec_zero     (rem_dec == '0),
    .state        (state),
    .noc_in_rdy   (noc_in_rdy),
    .hdr_out_val  (hdr_out_val),
    .data_out_val (data_out_val),
    .ld_hdr       (ld_hdr),
    .ld_meta      (ld_meta),
    .dec_rem      (dec_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      len_err_r <= 1'b0;
      src_ip_r  <= '0;
      dst_ip_r  <= '0;
      udp_hdr_r <= '0;
      pad_lsb_r <= '0;
    end else begin
      len_err_r <= ld_meta & ~len_ok;
      if (ld_hdr)       remaining <= hdr_in.msg_len;
      else if (dec_rem) remaining <= rem_dec;
      if (ld_meta) begin
        src_ip_r  <= meta_in.src_ip;
        dst_ip_r  <= meta_in.dst_ip;
        udp_hdr_r <= '{src_port: meta_in.src_port,
                       dst_port: meta_in.dst_port,
                       length:   meta_in.data_length + 16'(UDP_HDR_BYTES),
                       chksum:   16'h0};
        pad_lsb_r <= meta_in.data_length[BYTES_W-1:0];
      end
    end
  end

`ifdef UDP_TX_NOC_IN_TIMESTAMP_EN
  tracker_stats_struct stats_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stats_r <= '0;
    else if (ld_hdr) stats_r <= hdr_in.stats;
  end

  assign hdr_out_timestamp = stats_r;
  assign unused_hdr_bits   = ^{hdr_in.dst_id, hdr_in.src_id, hdr_in.msg_type};
`else
  assign hdr_out_timestamp = '0;
  assign unused_hdr_bits   = ^{hdr_in.dst_id, hdr_in.src_id, hdr_in.msg_type, hdr_in.stats};
`endif

  assign hdr_out_src_ip  = src_ip_r;
  assign hdr_out_dst_ip  = dst_ip_r;
  assign hdr_out_udp_hdr = udp_hdr_r;
  assign len_err         = len_err_r;

  assign data_out_data     = (state == ST_DATA) ? noc_in_data : '0;
  assign data_out_last     = (state == ST_DATA) && rem_one;
  assign data_out_padbytes = (data_out_last && pad_lsb_r != '0)
                             ? PAD_W'(DATA_BYTES) - PAD_W'(pad_lsb_r) : '0;

endmodule

// File: tb/tb_udp_tx_noc_in_param.sv
// Directed bench for udp_tx_noc_in_param at DATA_W=512.
module tb_udp_tx_noc_in_param;
  import udp_tx_pkg::*;

  localparam int DATA_W = 512;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                noc_in_val;
  logic [DATA_W-1:0]   noc_in_data;
  logic                noc_in_rdy;
  logic                hdr_out_val;
  logic                hdr_out_rdy;
  logic [31:0]         hdr_out_src_ip;
  logic [31:0]         hdr_out_dst_ip;
  udp_pkt_hdr          hdr_out_udp_hdr;
  tracker_stats_struct hdr_out_timestamp;
  logic                data_out_val;
  logic                data_out_rdy;
  logic [DATA_W-1:0]   data_out_data;
  logic                data_out_last;
  logic [6:0]          data_out_padbytes;
  logic                len_err;

  always #5 clk = ~clk;

  udp_tx_noc_in_param #(.DATA_W(DATA_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .noc_in_val        (noc_in_val),
    .noc_in_data       (noc_in_data),
    .noc_in_rdy        (noc_in_rdy),
    .hdr_out_val       (hdr_out_val),
    .hdr_out_rdy       (hdr_out_rdy),
    .hdr_out_src_ip    (hdr_out_src_ip),
    .hdr_out_dst_ip    (hdr_out_dst_ip),
    .hdr_out_udp_hdr   (hdr_out_udp_hdr),
    .hdr_out_timestamp (hdr_out_timestamp),
    .data_out_val      (data_out_val),
    .data_out_rdy      (data_out_rdy),
    .data_out_data     (data_out_data),
    .data_out_last     (data_out_last),
    .data_out_padbytes (data_out_padbytes),
    .len_err           (len_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] dq[$];
  logic        lq[$];
  logic [6:0]  pq[$];
  udp_pkt_hdr  hq[$];
  logic [31:0] iq[$];
  int          n_len_err = 0;
  logic        mirror_arm = 1'b0;
  logic        mirror_on  = 1'b0;
  logic        tog_on     = 1'b0;

  // Output monitor, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (mirror_on) chk("rdy_mirror", 64'(noc_in_rdy), 64'(data_out_rdy));
    if (len_err) n_len_err++;
    if (hdr_out_val && hdr_out_rdy) begin
      hq.push_back(hdr_out_udp_hdr);
      iq.push_back(hdr_out_src_ip);
      if (mirror_arm) begin
        mirror_on  = 1'b1;
        mirror_arm = 1'b0;
      end
    end
    if (data_out_val && data_out_rdy) begin
      dq.push_back(data_out_data[63:0]);
      lq.push_back(data_out_last);
      pq.push_back(data_out_padbytes);
      if (data_out_last) mirror_on = 1'b0;
    end
  end

  // data_out_rdy pattern 1-0-0-1 while tog_on
  initial begin
    int pi;
    logic [3:0] pat;
    pat = 4'b1001;
    pi  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tog_on) begin
        data_out_rdy = pat[3-pi];
        pi = (pi + 1) % 4;
      end else begin
        pi = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] mk_hdr(input logic [7:0] ml, input logic [15:0] pid);
    beehive_noc_hdr_flit h;
    logic [DATA_W-1:0]   f;
    h = '0;
    h.msg_type = 8'h11;
    h.msg_len  = ml;
    h.stats.packet_id = pid;
    h.stats.timestamp = {48'h0, pid} + 64'h1000;
    f = {DATA_W{1'b1}};
    f[$bits(beehive_noc_hdr_flit)-1:0] = h;
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] mk_meta(input logic [15:0] sp, input logic [15:0] dp,
                                                input logic [15:0] dl);
    udp_tx_metadata_flit m;
    logic [DATA_W-1:0]   f;
    m.src_ip      = 32'h0a00_0001;
    m.dst_ip      = 32'h0a00_0002;
    m.src_port    = sp;
    m.dst_port    = dp;
    m.data_length = dl;
    f = '0;
    f[$bits(udp_tx_metadata_flit)-1:0] = m;
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] mk_beat(input logic [63:0] tag);
    return {8{tag}};
  endfunction

  task automatic send_flit(input logic [DATA_W-1:0] d, output int cyc);
    bit done;
    done = 1'b0;
    cyc  = 0;
    noc_in_val  = 1'b1;
    noc_in_data = d;
    while (!done && cyc < 200) begin
      @(negedge clk);
      done = noc_in_rdy;
      @(posedge clk);
      #1;
      cyc++;
    end
    noc_in_val = 1'b0;
    if (!done) chk("send_timeout", 64'(done), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    dq.delete(); lq.delete(); pq.delete(); hq.delete(); iq.delete();
  endtask

  initial begin
    int c;
    logic [63:0] tag_ab [4];
    logic        last_ab[4];
    logic [6:0]  pad_ab [4];
    logic [63:0] tag_d  [4];

    tag_ab  = '{64'hA1, 64'hA2, 64'hB1, 64'hB2};
    last_ab = '{1'b0, 1'b1, 1'b0, 1'b1};
    pad_ab  = '{7'd0, 7'd28, 7'd0, 7'd0};
    tag_d   = '{64'hD1, 64'hD2, 64'hD3, 64'hD4};

    rst_n        = 1'b0;
    noc_in_val   = 1'b0;
    noc_in_data  = '0;
    hdr_out_rdy  = 1'b0;
    data_out_rdy = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_noc_in_rdy", 64'(noc_in_rdy), 64'd0);
    chk("rst_hdr_val", 64'(hdr_out_val), 64'd0);
    chk("rst_data_val", 64'(data_out_val), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_udp_hdr", 64'(hdr_out_udp_hdr), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    chk("rdy_after_release", 64'(noc_in_rdy), 64'd1);

    // 100 bytes, 5000->6000, header held while hdr_out_rdy low
    send_flit(mk_hdr(8'd3, 16'd1), c);
    send_flit(mk_meta(16'd5000, 16'd6000, 16'd100), c);
    chk("hdr_val_early", 64'(hdr_out_val), 64'd1);
    idle(3);
    chk("hdr_val_held", 64'(hdr_out_val), 64'd1);
    chk("hdr_len_held", 64'(hdr_out_udp_hdr.length), 64'd108);
    chk("hdr_sport", 64'(hdr_out_udp_hdr.src_port), 64'd5000);
    chk("hdr_dport", 64'(hdr_out_udp_hdr.dst_port), 64'd6000);
    chk("hdr_chksum", 64'(hdr_out_udp_hdr.chksum), 64'd0);
    chk("hdr_dst_ip", 64'(hdr_out_dst_ip), 64'h0a00_0002);
    chk("hdr_noc_rdy_low", 64'(noc_in_rdy), 64'd0);
`ifdef UDP_TX_NOC_IN_TIMESTAMP_EN
    chk("ts_pid", 64'(hdr_out_timestamp.packet_id), 64'd1);
    chk("ts_val", hdr_out_timestamp.timestamp, 64'h1001);
`else
    chk("ts_pid", 64'(hdr_out_timestamp.packet_id), 64'd0);
    chk("ts_val", hdr_out_timestamp.timestamp, 64'h0);
`endif
    hdr_out_rdy = 1'b1;
    send_flit(mk_beat(64'hA1), c);
    send_flit(mk_beat(64'hA2), c);
    // next header must be taken the cycle after the last beat
    send_flit(mk_hdr(8'd3, 16'd2), c);
    chk("b2b_hdr_cycles", 64'(c), 64'd1);
    send_flit(mk_meta(16'd1234, 16'd80, 16'd128), c);
    send_flit(mk_beat(64'hB1), c);
    send_flit(mk_beat(64'hB2), c);
    idle(2);
    chk("ab_hdr_count", 64'(hq.size()), 64'd2);
    chk("ab_beat_count", 64'(dq.size()), 64'd4);
    if (hq.size() == 2) begin
      chk("a_len", 64'(hq[0].length), 64'd108);
      chk("a_sport", 64'(hq[0].src_port), 64'd5000);
      chk("a_src_ip", 64'(iq[0]), 64'h0a00_0001);
      chk("b_len", 64'(hq[1].length), 64'd136);
      chk("b_dport", 64'(hq[1].dst_port), 64'd80);
    end
    if (dq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ab_tag%0d", i), dq[i], tag_ab[i]);
        chk($sformatf("ab_last%0d", i), 64'(lq[i]), 64'(last_ab[i]));
        chk($sformatf("ab_pad%0d", i), 64'(pq[i]), 64'(pad_ab[i]));
      end
    end
    clear_q();

    // length mismatch: 100 bytes need 2 flits, only 1 follows
    send_flit(mk_hdr(8'd2, 16'd3), c);
    send_flit(mk_meta(16'd1, 16'd2, 16'd100), c);
    send_flit(mk_beat(64'hDD), c);
    chk("drain_cycles", 64'(c), 64'd1);
    idle(3);
    chk("err_pulses", 64'(n_len_err), 64'd1);
    chk("err_no_hdr", 64'(hq.size()), 64'd0);
    chk("err_no_data", 64'(dq.size()), 64'd0);

    // header-only packet after the bad one
    send_flit(mk_hdr(8'd1, 16'd4), c);
    send_flit(mk_meta(16'd7, 16'd8, 16'd0), c);
    idle(3);
    chk("ho_hdr_count", 64'(hq.size()), 64'd1);
    if (hq.size() == 1) chk("ho_len", 64'(hq[0].length), 64'd8);
    chk("ho_no_data", 64'(dq.size()), 64'd0);
    clear_q();

    // 4 beats with data_out_rdy toggling
    mirror_arm = 1'b1;
    tog_on     = 1'b1;
    send_flit(mk_hdr(8'd5, 16'd5), c);
    send_flit(mk_meta(16'd9, 16'd10, 16'd256), c);
    for (int i = 0; i < 4; i++) send_flit(mk_beat(tag_d[i]), c);
    tog_on = 1'b0;
    #1;
    data_out_rdy = 1'b1;
    idle(2);
    chk("tog_beat_count", 64'(dq.size()), 64'd4);
    chk("tog_mirror_done", 64'(mirror_on), 64'd0);
    if (dq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tog_tag%0d", i), dq[i], tag_d[i]);
        chk($sformatf("tog_last%0d", i), 64'(lq[i]), (i == 3) ? 64'd1 : 64'd0);
        chk($sformatf("tog_pad%0d", i), 64'(pq[i]), 64'd0);
      end
    end
    clear_q();

    // reset during the second data beat
    send_flit(mk_hdr(8'd5, 16'd6), c);
    send_flit(mk_meta(16'd11, 16'd12, 16'd256), c);
    send_flit(mk_beat(64'hE1), c);
    noc_in_val  = 1'b1;
    noc_in_data = mk_beat(64'hE2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data_val", 64'(data_out_val), 64'd0);
    chk("mid_rst_noc_rdy", 64'(noc_in_rdy), 64'd0);
    chk("mid_rst_last", 64'(data_out_last), 64'd0);
    chk("mid_rst_hdr_val", 64'(hdr_out_val), 64'd0);
    noc_in_val = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("mid_rst_beats", 64'(dq.size()), 64'd1);
    clear_q();
    send_flit(mk_hdr(8'd2, 16'd7), c);
    send_flit(mk_meta(16'd40000, 16'd53, 16'd10), c);
    send_flit(mk_beat(64'hF1), c);
    idle(2);
    chk("fresh_hdr_count", 64'(hq.size()), 64'd1);
    if (hq.size() == 1) chk("fresh_len", 64'(hq[0].length), 64'd18);
    chk("fresh_beat_count", 64'(dq.size()), 64'd1);
    if (dq.size() == 1) begin
      chk("fresh_tag", dq[0], 64'hF1);
      chk("fresh_last", 64'(lq[0]), 64'd1);
      chk("fresh_pad", 64'(pq[0]), 64'd54);
    end
    chk("total_err_pulses", 64'(n_len_err), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
